// File: rtl/dm_access_unit.sv
// dm_access_unit: memory-stage initiator for a word-organised data memory.
// Takes one load/store at a time, performs sub-word extraction with sign/zero
// extension on loads and read-modify-write on sub-word stores, and reports
// misaligned or out-of-range accesses instead of touching memory.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_op[2:0]              000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//   req_addr, req_wdata, req_pc   byte address, store data, instruction PC
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load result (0 for stores/faults)
//   exc_adel / exc_ades      load / store address fault, valid with resp_valid
//   dm_we, dm_addr, dm_wd, dm_pc  memory port (word-aligned address)
//   dm_rd                    memory read data, combinational from dm_addr
module dm_access_unit #(
  parameter int unsigned DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LW  = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010, OP_LB = 3'b011,
    OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH  = 3'b110, OP_SB = 3'b111
  } op_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

  state_t      state, state_next;
  op_t         op_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q, merge_q;
  logic        adel_q, ades_q;

  logic        misaligned, fault, store_req, load_q, subword_store_q;
  logic [31:0] aligned_addr, load_val, merged;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Fault evaluation on the incoming request; feeds only the state and the
  // latched flags, never the memory port.
  always_comb begin
    misaligned = 1'b0;
    case (op_t'(req_op))
      OP_LW, OP_SW:         misaligned = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      default:              misaligned = 1'b0;
    endcase
    fault     = misaligned | (req_addr >= ADDR_LIMIT);
    store_req = req_op[2] & (req_op[1] | req_op[0]);
  end

  assign load_q          = (op_q inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU});
  assign subword_store_q = (op_q inside {OP_SH, OP_SB});
  assign aligned_addr    = {addr_q[31:2], 2'b00};

  // Load field selection and extension from the current memory word.
  always_comb begin
    half_sel = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    byte_sel = dm_rd[{addr_q[1:0], 3'b000} +: 8];
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = dm_rd;
    endcase
  end

  // Read-modify-write merge of the stored half/byte into the latched word.
  always_comb begin
    merged = merge_q;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = fault ? DONE : ACCESS;
      ACCESS:  state_next = subword_store_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, load result and merge register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q    <= op_t'(req_op);
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          pc_q    <= req_pc;
          rdata_q <= '0;
          merge_q <= '0;
          adel_q  <= fault & ~store_req;
          ades_q  <= fault & store_req;
        end
        ACCESS: begin
          if (load_q)               rdata_q <= load_val;
          else if (subword_store_q) merge_q <= dm_rd;
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory port driven from state and latches only.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    resp_rdata = (state == DONE) ? rdata_q : '0;
    exc_adel   = (state == DONE) & adel_q;
    exc_ades   = (state == DONE) & ades_q;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_wd      = '0;
    dm_pc      = pc_q;
    case (state)
      ACCESS: begin
        dm_addr = aligned_addr;
        if (op_q == OP_SW) begin
          dm_we = 1'b1;
          dm_wd = wdata_q;
        end
      end
      WRITE: begin
        dm_we   = 1'b1;
        dm_addr = aligned_addr;
        dm_wd   = merged;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Memory-stage initiator for the word-organised data memory (3072 × 32-bit, combinational read, write on rising clock edge). Accepts one load/store request at a time from the pipeline's M stage and drives the memory's WE/addr/WD/PC port. Performs sign/zero extension for sub-word loads and read-modify-write for sub-word stores. Flags misaligned or out-of-range accesses instead of touching memory.

## Interface
- `DM_WORDS`, default 3072: memory depth in words; valid byte addresses are 0 to 4·DM_WORDS−1 (0x0000–0x2FFF).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_op` in 3: operation code: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; SH uses [15:0], SB uses [7:0].
- `req_pc` in 32: PC of the instruction; forwarded to memory.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and faults.
- `exc_adel` out 1: load fault, valid with `resp_valid`.
- `exc_ades` out 1: store fault, valid with `resp_valid`.
- `dm_we` out 1: memory write enable.
- `dm_addr` out 32: word-aligned byte address to memory.
- `dm_wd` out 32: memory write data.
- `dm_pc` out 32: PC to memory.
- `dm_rd` in 32: memory read data, combinational from `dm_addr`.

## Operation
- Little-endian layout: byte k = bits [8k+7:8k], k = addr[1:0]; half = [15:0] if addr[1]=0, [31:16] if addr[1]=1.
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op/addr/wdata/pc and evaluate faults.
  - Fault: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1; any addr ≥ 4·DM_WORDS.
  - On a fault, go to DONE with `exc_adel` (loads) or `exc_ades` (stores) set. The memory is never accessed.
  - With no fault, go to ACCESS.
- ACCESS: `dm_addr` = {addr[31:2], 2'b00}.
  - LW: latch `dm_rd` into `resp_rdata`.
  - LH/LB: latch the selected field, sign-extended, into `resp_rdata`.
  - LHU/LBU: latch the selected field, zero-extended, into `resp_rdata`.
  - After any load, go to DONE.
  - SW: `dm_we`=1, `dm_wd`=wdata; go to DONE.
  - SH/SB: latch `dm_rd` into the merge register; go to WRITE.
- WRITE: `dm_we`=1, `dm_addr` unchanged. `dm_wd` = merge register with the target half/byte replaced by wdata[15:0]/[7:0]. Go to DONE.
- DONE:
  - `resp_valid`=1 for exactly one cycle.
  - `resp_rdata` = load result (0 for stores and faults).
  - Exception flags are valid this cycle.
  - Return to IDLE.
- `dm_we`, `dm_addr`, `dm_wd`, `dm_pc` are driven only from state and latched registers. There is no combinational path from `req_*` to `dm_*`.
- `dm_we` is 0 in IDLE and DONE. `dm_pc` = latched pc in every state.
- `req_valid` while busy is ignored, not queued. The requester must hold the request until it sees `req_ready`.

## Timing
- Accept edge = E0.
- LW/LH/LHU/LB/LBU/SW: ACCESS in cycle 1, `resp_valid` in cycle 2; request-to-response latency 2.
- SH/SB: read in cycle 1, write in cycle 2, `resp_valid` in cycle 3; latency 3.
- Fault: `resp_valid` in cycle 1; latency 1; `dm_we` never asserted.
- `req_ready` is 0 from E0 through the DONE cycle and 1 again the cycle after DONE. Back-to-back throughput is one request per 3 or 4 cycles.
- Store-then-load to the same word: the load's ACCESS follows the store's write edge, so it returns the new data.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `exc_adel`/`exc_ades` 0, `dm_we` 0, `dm_addr`/`dm_wd`/`dm_pc` 0.
- `rst` mid-operation, in any state:
  - The next edge returns to IDLE and clears all latches.
  - No `resp_valid` is produced for the aborted request.
  - A WRITE coinciding with `rst` is discarded, because the memory's reset takes priority.

## Test plan
- Reset, then SW addr 0x0010 wdata 0xDEADBEEF, pc 0x3000 → `dm_we`=1 with `dm_addr` 0x10 in cycle 1; `resp_valid` in cycle 2. A following LW 0x0010 → `resp_rdata` 0xDEADBEEF, 2 cycles after accept.
- After the above: LB 0x0013 → 0xFFFFFFDE; LBU 0x0013 → 0x000000DE; LH 0x0012 → 0xFFFFDEAD; LHU 0x0010 → 0x0000BEEF.
- SB 0x0011 wdata 0x12, then LW 0x0010 → 0xDEAD12EF. The SB shows one read cycle then one `dm_we` cycle, with `resp_valid` 3 cycles after accept.
- SH 0x0012 wdata 0xCAFE → word becomes 0xCAFE12EF. A `req_valid` held during the busy cycles is accepted only after `req_ready` returns.
- LW 0x0002 → `exc_adel`=1 at latency 1. SH 0x0001 → `exc_ades`=1. SW 0x3000 → `exc_ades`=1. In all three, `dm_we` stays 0 and the memory contents are unchanged.
- Assert `rst` during the WRITE cycle of an SB → no `resp_valid`, `dm_we` 0 after the edge, `req_ready` 1. A subsequent LW of that word returns 0.
